// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs RV32-style instruction fields plus a signed byte-offset immediate
//   into a 32-bit instruction word. A request is accepted in IDLE, encoded in
//   ENCODE, then offered in HOLD until the consumer takes it.
//
// Ports
//   clk        : single clock, all state on rising edge
//   reset      : synchronous active-low reset
//   in_valid   : request present          in_ready  : encoder idle, can accept
//   immSrc     : 00 I, 01 S, 10 B, 11 R   immIn     : signed byte offset
//   opcode, funct3, funct7, rd, rs1, rs2  : instruction fields
//   out_valid  : encoded word available   out_ready : consumer takes word
//   instr      : encoded instruction      err       : immediate not representable
//   enc_count  : handshakes completed (wraps)
//   err_count  : handshakes with err=1 (saturates at 255)
// -----------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  immSrc,
  input  logic [31:0] immIn,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENCODE = 2'b01,
    ST_HOLD   = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_R = 2'b11
  } fmt_e;

  // State and registered outputs
  state_e      state_q,     state_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q,     instr_d;
  logic        err_q,       err_d;
  logic [15:0] enc_count_q, enc_count_d;
  logic [7:0]  err_count_q, err_count_d;

  // Captured request
  fmt_e        fmt_q,    fmt_d;
  logic [31:0] imm_q,    imm_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [4:0]  rd_q,     rd_d;
  logic [4:0]  rs1_q,    rs1_d;
  logic [4:0]  rs2_q,    rs2_d;

  // Encoder datapath results (from captured request only)
  logic [31:0] enc_word;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;

  // A value fits an N-bit signed field when all bits from N-1 upward are
  // copies of the sign, i.e. all-ones or all-zeros.
  always_comb begin
    fits_12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    fits_13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  end

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (fmt_q)
      FMT_I: begin
        enc_err  = ~fits_12;
        enc_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
      end
      FMT_S: begin
        enc_err  = ~fits_12;
        enc_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
      end
      FMT_B: begin
        // 13-bit signed range with an even offset; the top odd value 4095 is
        // excluded by the alignment test, giving -4096..4094.
        enc_err  = ~fits_13 | imm_q[0];
        enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                    imm_q[4:1], imm_q[11], opcode_q};
      end
      FMT_R: begin
        enc_err  = 1'b0;
        enc_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
      end
      default: begin
        enc_err  = 1'b0;
        enc_word = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    fmt_d       = fmt_q;
    imm_d       = imm_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    funct7_d    = funct7_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          fmt_d      = fmt_e'(immSrc);
          imm_d      = immIn;
          opcode_d   = opcode;
          funct3_d   = funct3;
          funct7_d   = funct7;
          rd_d       = rd;
          rs1_d      = rs1;
          rs2_d      = rs2;
          in_ready_d = 1'b0;
          state_d    = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        err_d       = enc_err;
        instr_d     = enc_err ? '0 : enc_word;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          enc_count_d = enc_count_q + 16'd1;
          if (err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
      fmt_q       <= FMT_I;
      imm_q       <= '0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
      fmt_q       <= fmt_d;
      imm_q       <= imm_d;
      opcode_q    <= opcode_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder: directed examples, boundary
//   immediates, reset during ENCODE/HOLD, randomized requests and err_count
//   saturation, all compared against a field-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  immSrc;
  logic [31:0] immIn;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immSrc    (immSrc),
    .immIn     (immIn),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [1:0]  src;
    int          imm;
    int unsigned op, f3, f7, rd, rs1, rs2;
  } req_t;

  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_enc  = 0;
  int unsigned exp_errc = 0;
  logic [31:0] seen_instr;
  logic        seen_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: representability by signed integer ranges, packing by
  // shifting and masking the integer offset into its instruction bit spots.
  function automatic bit ref_err(input logic [1:0] src, input int imm);
    case (src)
      2'b00, 2'b01: return (imm < -2048) || (imm > 2047);
      2'b10:        return (imm < -4096) || (imm > 4094) || ((imm % 2) != 0);
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_instr(input req_t r);
    int unsigned u;
    int unsigned w;
    if (ref_err(r.src, r.imm)) return 32'h0;
    u = r.imm;
    w = r.op + (r.f3 << 12);
    case (r.src)
      2'b00: w += ((u & 32'hFFF) << 20) + (r.rs1 << 15) + (r.rd << 7);
      2'b01: w += (((u >> 5) & 32'h7F) << 25) + (r.rs2 << 20) + (r.rs1 << 15)
                  + ((u & 32'h1F) << 7);
      2'b10: w += (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3F) << 25)
                  + (r.rs2 << 20) + (r.rs1 << 15) + (((u >> 1) & 32'hF) << 8)
                  + (((u >> 11) & 1) << 7);
      default: w += (r.f7 << 25) + (r.rs2 << 20) + (r.rs1 << 15) + (r.rd << 7);
    endcase
    return w;
  endfunction

  function automatic req_t mk(input logic [1:0] src, input int imm, input int unsigned op,
                              input int unsigned f3, input int unsigned f7, input int unsigned rdv,
                              input int unsigned rs1v, input int unsigned rs2v);
    req_t r;
    r.src = src; r.imm = imm; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rdv; r.rs1 = rs1v; r.rs2 = rs2v;
    return r;
  endfunction

  task automatic drive(input req_t r);
    immSrc = r.src;
    immIn  = r.imm;
    opcode = r.op[6:0];
    funct3 = r.f3[2:0];
    funct7 = r.f7[6:0];
    rd     = r.rd[4:0];
    rs1    = r.rs1[4:0];
    rs2    = r.rs2[4:0];
  endtask

  task automatic scramble();
    immSrc   = 2'($urandom);
    immIn    = $urandom;
    opcode   = 7'($urandom);
    funct3   = 3'($urandom);
    funct7   = 7'($urandom);
    rd       = 5'($urandom);
    rs1      = 5'($urandom);
    rs2      = 5'($urandom);
    in_valid = 1'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'h1);
  endtask

  // Full request: accept, ENCODE, HOLD for 'hold' stalled cycles, handshake.
  task automatic run_req(input req_t r, input int hold);
    logic [31:0] ei;
    logic        ee;
    ei = ref_instr(r);
    ee = ref_err(r.src, r.imm);
    wait_ready();
    @(negedge clk);
    drive(r);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("encode_in_ready", {31'b0, in_ready}, 32'h0);
    check("encode_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    scramble();
    @(posedge clk); #1;
    check("hold_out_valid", {31'b0, out_valid}, 32'h1);
    check("instr", instr, ei);
    check("err", {31'b0, err}, {31'b0, ee});
    seen_instr = instr;
    seen_err   = err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble();
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_out_valid", {31'b0, out_valid}, 32'h1);
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_instr", instr, ei);
      check("stall_enc_count", {16'b0, enc_count}, exp_enc & 32'hFFFF);
    end
    @(negedge clk);
    scramble();
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp_enc = (exp_enc + 1) & 32'hFFFF;
    if (ee && exp_errc < 255) exp_errc++;
    check("done_out_valid", {31'b0, out_valid}, 32'h0);
    check("done_in_ready", {31'b0, in_ready}, 32'h1);
    check("enc_count", {16'b0, enc_count}, exp_enc);
    check("err_count", {24'b0, err_count}, exp_errc);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_err"}, {31'b0, err}, 32'h0);
    check({tag, "_enc_count"}, {16'b0, enc_count}, 32'h0);
    check({tag, "_err_count"}, {24'b0, err_count}, 32'h0);
  endtask

  // Accept a request, then assert reset after 'stage' cycles (1=ENCODE, 2=HOLD).
  task automatic reset_mid(input req_t r, input int stage, input string tag);
    wait_ready();
    @(negedge clk);
    drive(r);
    in_valid = 1'b1;
    @(posedge clk);
    for (int s = 1; s < stage; s++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
    exp_enc  = 0;
    exp_errc = 0;
    check_reset_state(tag);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check({tag, "_dropped"}, {31'b0, out_valid}, 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int bvals[16] = '{-4097, -4096, -4095, -2049, -2048, -2047, 2046, 2047,
                    2048, 4093, 4094, 4095, 4096, 0, 1, -1};

  initial begin
    req_t r;
    int   imm;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(mk(2'b00, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    // Directed examples
    run_req(mk(2'b00, -4, 7'b0000011, 3'b010, 0, 5, 2, 0), 0);
    check("i_example", seen_instr, 32'hFFC12283);
    run_req(mk(2'b01, 8, 7'b0100011, 3'b010, 0, 0, 2, 6), 1);
    check("s_example", seen_instr, 32'h00612423);
    run_req(mk(2'b10, -8, 7'b1100011, 3'b000, 0, 0, 1, 2), 0);
    check("b_example", seen_instr, 32'hFE208CE3);
    run_req(mk(2'b10, 5, 7'b1100011, 3'b000, 0, 0, 1, 2), 0);
    check("b_odd_err", {31'b0, seen_err}, 32'h1);
    check("b_odd_instr", seen_instr, 32'h0);
    check("b_odd_err_count", {24'b0, err_count}, 32'h1);
    run_req(mk(2'b00, 2048, 7'b0010011, 3'b000, 0, 3, 4, 0), 0);
    check("i_2048_err", {31'b0, seen_err}, 32'h1);
    run_req(mk(2'b00, 2047, 7'b0010011, 3'b000, 0, 3, 4, 0), 0);
    check("i_2047_imm", {20'b0, seen_instr[31:20]}, 32'h7FF);
    run_req(mk(2'b11, 12345, 7'b0110011, 3'b000, 7'b0100000, 9, 10, 11), 3);

    // Reset in flight drops the request and clears statistics
    reset_mid(mk(2'b00, 1, 7'b0010011, 3'b000, 0, 1, 1, 0), 1, "rst_encode");
    reset_mid(mk(2'b10, 3, 7'b1100011, 3'b001, 0, 0, 1, 2), 2, "rst_hold");

    // Randomized requests
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(3))
        0: imm = int'($urandom);
        1: imm = bvals[$urandom_range(15)];
        2: imm = int'($urandom_range(10000)) - 5000;
        default: imm = int'($urandom_range(32)) - 16;
      endcase
      r = mk(2'($urandom), imm, $urandom_range(127), $urandom_range(7),
             $urandom_range(127), $urandom_range(31), $urandom_range(31),
             $urandom_range(31));
      run_req(r, int'($urandom_range(3)));
    end

    // Push err_count into saturation
    for (int i = 0; i < 260; i++) begin
      r = mk(2'b10, int'($urandom_range(2000)) * 2 + 1, 7'b1100011, 0, 0, 0, 1, 2);
      run_req(r, 0);
    end
    check("err_count_sat", {24'b0, err_count}, 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
